// File: rtl/register_file_if.sv
// register_file_if: write/read bus of the register file.
// Revision: 1.0 - initial release.
`default_nettype none

interface register_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              WE;
  logic [ADDR_W-1:0] WA;
  logic [DATA_W-1:0] WD;
  logic [ADDR_W-1:0] RA1;
  logic [ADDR_W-1:0] RA2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;

  modport master (output WE, WA, WD, RA1, RA2, input RD1, RD2);
  modport slave  (input WE, WA, WD, RA1, RA2, output RD1, RD2);
endinterface

`default_nettype wire

// File: rtl/register_file.sv
// register_file: 2**ADDR_W x DATA_W, one write port, two combinational read ports, reg 0 = 0.
// Optional write-to-read forwarding: REGFILE_BYPASS_EN.  Revision: 1.0 - initial release.
`default_nettype none

module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  wire             CLK,
  input  wire             RST_N,
  register_file_if.slave  bus
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0]             wen;
  logic [NREG-1:0][DATA_W-1:0] mem;

  // One-hot write decode; bit 0 forced low so writes to address 0 vanish.
  always_comb begin
    wen = '0;
    if (bus.WE) begin
      wen[bus.WA] = 1'b1;
    end
    wen[0] = 1'b0;
  end

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign mem[i] = '0;
      end else begin : g_store
        logic [DATA_W-1:0] q;
        always_ff @(posedge CLK) begin
          if (!RST_N) begin
            q <= '0;
          end else if (wen[i]) begin
            q <= bus.WD;
          end
        end
        assign mem[i] = q;
      end
    end
  endgenerate

`ifdef REGFILE_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok = bus.WE && RST_N && (bus.WA != '0);
`endif

  always_comb begin
    bus.RD1 = mem[bus.RA1];
    bus.RD2 = mem[bus.RA2];
`ifdef REGFILE_BYPASS_EN
    if (fwd_ok && (bus.RA1 == bus.WA)) begin
      bus.RD1 = bus.WD;
    end
    if (fwd_ok && (bus.RA2 == bus.WA)) begin
      bus.RD2 = bus.WD;
    end
`endif
  end
endmodule

`default_nettype wire

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter DATA_W, default 32: width of each register and of the data ports.
REQ-002 Parameter ADDR_W, default 5: address width; register count is 2**ADDR_W (32).
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST_N  input  1  synchronous, active-low reset, sampled on rising edge of CLK.
REQ-005 WE  input  1  write enable; high requests a write at the next rising edge.
REQ-006 WA  input  ADDR_W  write address; the demultiplexer select steering WD to one register.
REQ-007 WD  input  DATA_W  write data.
REQ-008 RA1  input  ADDR_W  read address, port 1.
REQ-009 RA2  input  ADDR_W  read address, port 2.
REQ-010 RD1  output  DATA_W  read data, port 1.
REQ-011 RD2  output  DATA_W  read data, port 2.

Function
REQ-012 Write path SHALL decode WA into a one-hot enable; at a rising CLK edge with RST_N=1 and WE=1, only register[WA] SHALL load WD.
REQ-013 Register 0 SHALL be hardwired to zero; writes to WA=0 SHALL be discarded with no other side effect.
REQ-014 WE=0 SHALL leave all registers unchanged.
REQ-015 Read ports SHALL be combinational: RD1=register[RA1], RD2=register[RA2], with zero-cycle latency and no clock dependence.
REQ-016 RA1=0 or RA2=0 SHALL always return all zeros.
REQ-017 RA1=RA2 SHALL return identical data on both ports.
REQ-018 Without bypass (see Configuration), a value written at edge N SHALL be visible on RD1/RD2 from immediately after edge N, and not before.
REQ-019 Changes to WA, WD or WE between edges SHALL have no effect on stored state.
REQ-020 Writes SHALL be exactly DATA_W bits wide: no partial writes and no sign or zero extension.

Reset
REQ-021 At a rising CLK edge with RST_N=0, all registers SHALL clear to 0, so RD1=RD2=0 from immediately after that edge.
REQ-022 Reset SHALL take priority over a simultaneous write: with RST_N=0 and WE=1 at the same edge, the write is dropped.
REQ-023 RST_N low between edges SHALL have no effect; reads keep returning current contents until the next edge.
REQ-024 Deasserting RST_N mid-operation SHALL resume normal writes at the first edge with RST_N=1.

Configuration
REQ-025 Macro REGFILE_BYPASS_EN defined: when WE=1, RST_N=1, WA!=0 and RAx=WA, RDx SHALL combinationally present WD in the same cycle, before the edge.
REQ-026 Macro REGFILE_BYPASS_EN undefined: RDx SHALL always present stored contents, with no forwarding path synthesized.
REQ-027 In both builds, bypass SHALL never apply to address 0 or while RST_N=0.

Verification
REQ-028 Reset with RST_N=0 for one edge, then sweep RA1/RA2 over 0..31 -> all reads 0.
REQ-029 Write 0xDEADBEEF to WA=5, then RA1=5 and RA2=5 -> both return 0xDEADBEEF after the edge; all other addresses still 0.
REQ-030 Write 0xFFFFFFFF to WA=0, then RA1=0 -> returns 0x00000000.
REQ-031 WE=1, WA=7, WD=0x12345678, RA1=7, checked before the edge -> 0x12345678 with REGFILE_BYPASS_EN, prior value 0 without it; 0x12345678 in both builds after the edge.
REQ-032 Write 0xA5A5A5A5 to reg 3, then RST_N=0 with WE=1, WA=3, WD=0x11111111 at the same edge -> RA1=3 returns 0.
REQ-033 Fill regs 1..31 with value=address via 31 back-to-back writes, then read RA1=k and RA2=31-k for all k -> RD1=k (0 for k=0) and RD2=31-k (0 for k=31).
